// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Fibonacci LFSR generator and checker pair.
package lfsr_pkg;

  localparam int          LFSR_W  = 8;
  localparam logic [7:0]  TAP     = 8'b00011101;
  localparam logic [7:0]  SEG_OFF = 8'hFF;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Next serial bit of the sequence given the 8 most recent bits (bit0 oldest).
  function automatic logic predict(input logic [LFSR_W-1:0] w);
    return ^(w & TAP);
  endfunction

endpackage

// File: rtl/lfsr_checker_hex7seg.sv
// Hex digit to active-low seven-segment pattern (bit7..bit1 = a..g, bit0 = dp, dp off).
module hex7seg
  import lfsr_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'h0: seg = ~8'b11111100;
      4'h1: seg = ~8'b01100000;
      4'h2: seg = ~8'b11011010;
      4'h3: seg = ~8'b11110010;
      4'h4: seg = ~8'b01100110;
      4'h5: seg = ~8'b10110110;
      4'h6: seg = ~8'b10111110;
      4'h7: seg = ~8'b11100000;
      4'h8: seg = ~8'b11111110;
      4'h9: seg = ~8'b11110110;
      4'hA: seg = ~8'b11101110;
      4'hB: seg = ~8'b00111110;
      4'hC: seg = ~8'b10011100;
      4'hD: seg = ~8'b01111010;
      4'hE: seg = ~8'b10011110;
      4'hF: seg = ~8'b10001110;
    endcase
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising receiver for the 8-bit LFSR stream; counts mismatches once locked.
// Optional LOCK_DP_EN: light the hex0 decimal point while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int VERIFY_LEN = 8,
  parameter int MISS_MAX   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       locked,
  output logic [7:0] err_cnt,
  output logic [7:0] hex1,
  output logic [7:0] hex0
);

  localparam logic [7:0] VLEN = VERIFY_LEN[7:0];
  localparam logic [3:0] MMAX = MISS_MAX[3:0];

  state_t            state;
  logic [LFSR_W-1:0] w;
  logic [3:0]        fill;
  logic [7:0]        run;
  logic [3:0]        miss;
  logic              pred;
  logic [7:0]        seg_hi;
  logic [7:0]        seg_lo;

  assign pred = predict(w);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SYNC;
      w       <= '0;
      fill    <= '0;
      run     <= '0;
      miss    <= '0;
      err_cnt <= '0;
      locked  <= 1'b0;
    end else if (bit_valid) begin
      case (state)
        SYNC: begin
          w    <= {bit_in, w[LFSR_W-1:1]};
          fill <= fill + 4'd1;
          if (fill == 4'(LFSR_W - 1)) begin
            state <= VERIFY;
            run   <= '0;
          end
        end
        VERIFY: begin
          w <= {bit_in, w[LFSR_W-1:1]};
          // An all-zero window is the LFSR lock-up state and predicts nothing useful.
          if (w == '0) begin
            state <= SYNC;
            fill  <= '0;
          end else if (bit_in == pred) begin
            run <= run + 8'd1;
            if (run + 8'd1 == VLEN) begin
              state  <= LOCKED;
              locked <= 1'b1;
              miss   <= '0;
            end
          end else begin
            state <= SYNC;
            fill  <= '0;
          end
        end
        LOCKED: begin
          if (bit_in == pred) begin
            w    <= {bit_in, w[LFSR_W-1:1]};
            miss <= '0;
          end else begin
            // Flywheel on the prediction so a single flipped bit costs one error.
            w    <= {pred, w[LFSR_W-1:1]};
            miss <= miss + 4'd1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (miss + 4'd1 == MMAX) begin
              state  <= SYNC;
              fill   <= '0;
              locked <= 1'b0;
            end
          end
        end
        default: begin
          state  <= SYNC;
          fill   <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

  hex7seg u_hex_hi (
    .digit (err_cnt[7:4]),
    .seg   (seg_hi)
  );

  hex7seg u_hex_lo (
    .digit (err_cnt[3:0]),
    .seg   (seg_lo)
  );

  assign hex1 = seg_hi;
`ifdef LOCK_DP_EN
  assign hex0 = seg_lo & {7'h7F, ~locked};
`else
  assign hex0 = seg_lo;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised, model-checked bench for lfsr_checker (honours LOCK_DP_EN when defined).
module tb_lfsr_checker;

  localparam int VL = 8;
  localparam int MM = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       locked;
  logic [7:0] err_cnt;
  logic [7:0] hex1;
  logic [7:0] hex0;

  int total = 0;
  int bad   = 0;

  // reference model: bit history, mode 0=sync 1=verify 2=locked
  bit   hist[$];
  int   mode, fill, run, miss, err;
  logic [7:0] gen;

  string glyph[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  lfsr_checker #(.VERIFY_LEN(VL), .MISS_MAX(MM)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .locked    (locked),
    .err_cnt   (err_cnt),
    .hex1      (hex1),
    .hex0      (hex0)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_code(input int d);
    logic [7:0] m;
    string s;
    m = '0;
    s = glyph[d];
    for (int i = 0; i < s.len(); i++) m[7 - (int'(s[i]) - 97)] = 1'b1;
    return ~m;
  endfunction

  function automatic bit last_zero();
    for (int i = 1; i <= 8; i++) if (hist[hist.size() - i] != 1'b0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_back(1'b0);
    mode = 0; fill = 0; run = 0; miss = 0; err = 0;
  endtask

  task automatic model_step(input bit b);
    int  n;
    bit  p;
    n = hist.size();
    p = hist[n-8] ^ hist[n-6] ^ hist[n-5] ^ hist[n-4];
    if (mode == 0) begin
      hist.push_back(b);
      fill++;
      if (fill == 8) begin mode = 1; run = 0; end
    end else if (mode == 1) begin
      if (last_zero()) begin mode = 0; fill = 0; end
      else if (b == p) begin run++; if (run == VL) begin mode = 2; miss = 0; end end
      else begin mode = 0; fill = 0; end
      hist.push_back(b);
    end else begin
      if (b == p) begin hist.push_back(b); miss = 0; end
      else begin
        hist.push_back(p);
        miss++;
        if (err < 255) err++;
        if (miss == MM) begin mode = 0; fill = 0; end
      end
    end
    if (hist.size() > 32) void'(hist.pop_front());
  endtask

  task automatic checkOutput(input string tag);
    logic       e_locked;
    logic [7:0] e_hex0, e_hex1;
    e_locked = (mode == 2);
    e_hex1   = seg_code(err / 16);
    e_hex0   = seg_code(err % 16);
`ifdef LOCK_DP_EN
    if (e_locked) e_hex0[0] = 1'b0;
`endif
    total++;
    assert (locked === e_locked)
      else begin bad++; $error("[TB] FAIL %s locked: got %b want %b", tag, locked, e_locked); end
    total++;
    assert (err_cnt === 8'(err))
      else begin bad++; $error("[TB] FAIL %s err_cnt: got %h want %h", tag, err_cnt, 8'(err)); end
    total++;
    assert (hex1 === e_hex1)
      else begin bad++; $error("[TB] FAIL %s hex1: got %b want %b", tag, hex1, e_hex1); end
    total++;
    assert (hex0 === e_hex0)
      else begin bad++; $error("[TB] FAIL %s hex0: got %b want %b", tag, hex0, e_hex0); end
  endtask

  task automatic applyStimulus(input logic b, input logic v, input string tag);
    @(negedge clk);
    bit_in    = b;
    bit_valid = v;
    @(posedge clk);
    if (v) model_step(b);
    #1;
    checkOutput(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst       = 1'b1;
    bit_valid = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    checkOutput(tag);
    rst = 1'b0;
  endtask

  task automatic gen_bit(input bit flip, input string tag);
    logic b;
    b   = gen[0] ^ flip;
    gen = {gen[0] ^ gen[2] ^ gen[3] ^ gen[4], gen[7:1]};
    applyStimulus(b, 1'b1, tag);
  endtask

  function automatic logic [7:0] rand_seed();
    return 8'($urandom_range(1, 255));
  endfunction

  initial begin
    model_reset();
    do_reset("reset");

    // clean stream from seed 01: lock after 8 + VL bits
    gen = 8'h01;
    for (int i = 1; i <= 100; i++) begin
      gen_bit(1'b0, "clean");
      if (i == 8 + VL - 1) begin
        total++;
        assert (locked === 1'b0)
          else begin bad++; $error("[TB] FAIL early_lock: got %b want 0", locked); end
      end
      if (i == 8 + VL) begin
        total++;
        assert (locked === 1'b1)
          else begin bad++; $error("[TB] FAIL lock_time: got %b want 1", locked); end
      end
    end
    total++;
    assert (hex0 === 8'b00000011 || hex0 === 8'b00000010)
      else begin bad++; $error("[TB] FAIL clean_hex0: got %b want 0000001x", hex0); end

    // single flipped bit
    gen_bit(1'b1, "flip1");
    total++;
    assert (err_cnt === 8'd1 && hex0[7:1] === 7'b1001111 && locked === 1'b1)
      else begin bad++; $error("[TB] FAIL flip1: got err=%h hex0=%b locked=%b want 01/1001111x/1", err_cnt, hex0, locked); end
    for (int i = 0; i < 30; i++) gen_bit(1'b0, "after_flip1");

    // three consecutive flips drop lock, then relock on clean data
    do_reset("reset2");
    gen = rand_seed();
    for (int i = 0; i < 20; i++) gen_bit(1'b0, "lock2");
    for (int i = 0; i < 3; i++) gen_bit(1'b1, "burst");
    total++;
    assert (locked === 1'b0 && err_cnt === 8'd3)
      else begin bad++; $error("[TB] FAIL burst: got locked=%b err=%h want 0/03", locked, err_cnt); end
    for (int i = 0; i < 8 + VL; i++) gen_bit(1'b0, "relock");
    total++;
    assert (locked === 1'b1 && err_cnt === 8'd3)
      else begin bad++; $error("[TB] FAIL relock: got locked=%b err=%h want 1/03", locked, err_cnt); end

    // all-zero stream never locks
    do_reset("reset3");
    gen = 8'h00;
    for (int i = 0; i < 50; i++) gen_bit(1'b0, "zeros");
    total++;
    assert (locked === 1'b0 && err_cnt === 8'd0)
      else begin bad++; $error("[TB] FAIL zeros: got locked=%b err=%h want 0/00", locked, err_cnt); end

    // random gaps and random bit errors
    do_reset("reset4");
    gen = rand_seed();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) applyStimulus(1'($urandom), 1'b0, "rand_idle");
      else gen_bit($urandom_range(0, 15) == 0, "rand");
    end

    // saturation with isolated errors, then idle hold
    do_reset("reset5");
    gen = rand_seed();
    for (int i = 0; i < 20; i++) gen_bit(1'b0, "lock5");
    for (int i = 0; i < 300; i++) begin
      gen_bit(1'b1, "sat_err");
      gen_bit(1'b0, "sat_ok");
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'($urandom), 1'b0, "hold");
    total++;
    assert (err_cnt === 8'hFF && hex1 === 8'b01110001 && hex0[7:1] === 7'b0111000 && locked === 1'b1)
      else begin bad++; $error("[TB] FAIL saturate: got err=%h hex1=%b hex0=%b locked=%b", err_cnt, hex1, hex0, locked); end

    // reset mid-lock with errors pending
    do_reset("reset6");
    gen = 8'h01;
    for (int i = 0; i < 20; i++) gen_bit(1'b0, "lock6");
    for (int i = 0; i < 5; i++) begin
      gen_bit(1'b1, "err6");
      gen_bit(1'b0, "ok6");
    end
    total++;
    assert (err_cnt === 8'd5 && locked === 1'b1)
      else begin bad++; $error("[TB] FAIL pre_reset: got err=%h locked=%b want 05/1", err_cnt, locked); end
    do_reset("mid_reset");
    total++;
    assert (locked === 1'b0 && err_cnt === 8'd0 && hex0 === 8'b00000011)
      else begin bad++; $error("[TB] FAIL mid_reset: got locked=%b err=%h hex0=%b", locked, err_cnt, hex0); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
